// File: rtl/exotiny_board_pkg.sv
// Shared types and elaboration helpers for the exotiny board housekeeping logic.
package exotiny_board_pkg;

  typedef enum logic [1:0] {
    GPO_DIRECT = 2'd0,
    GPO_INV    = 2'd1,
    GPO_BLINK  = 2'd2,
    GPO_PWM    = 2'd3
  } gpo_mode_e;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } board_state_e;

  // Cycles to keep the SoC in reset while the QSPI memories power up.
  function automatic int hold_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Bits needed to hold max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/exotiny_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second
// rising clock edge after rst_n goes high.
module exotiny_rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

endmodule

// File: rtl/exotiny_board_ctrl.sv
// Board housekeeping between the FPGA pins and the exotiny SoC: reset
// conditioning with a memory power-up hold, status/activity LEDs and GPO modes.
module exotiny_board_ctrl
  import exotiny_board_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int STARTUP_US  = 150,
  parameter int GPOCNT      = 1,
  parameter int PWM_W       = 8,
  parameter int STRETCH_CYC = 1_200_000,
  parameter int BLINK_CYC   = 6_000_000
) (
  input  logic                clk_i,
  input  logic                rst_in,
  output logic                core_rst_no,
  input  logic                mem_cs_ram_ni,
  input  logic                mem_cs_rom_ni,
  input  logic [GPOCNT-1:0]   gpo_i,
  input  logic [2*GPOCNT-1:0] mode_i,
  input  logic [PWM_W-1:0]    duty_i,
  output logic [GPOCNT-1:0]   gpo_o,
  output logic                led_g_no,
  output logic                led_r_no
);

  localparam int HOLD_CYC = hold_cycles(CLK_HZ, STARTUP_US);
  localparam int HOLD_W   = cnt_width((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam int STR_W    = cnt_width(STRETCH_CYC);
  localparam int BLINK_W  = cnt_width((BLINK_CYC > 0) ? BLINK_CYC - 1 : 0);

  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [STR_W-1:0]   STRETCH_LOAD = STR_W'(STRETCH_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'((BLINK_CYC > 0) ? BLINK_CYC - 1 : 0);

  logic rst_n;

  exotiny_rst_sync u_rst_sync (
    .clk        (clk_i),
    .rst_n      (rst_in),
    .rst_sync_n (rst_n)
  );

  board_state_e        state_q;
  board_state_e        state_d;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                run;
  logic                run_d;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET: begin
        if (HOLD_CYC == 0) begin
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    run   = (state_q == RUN);
    run_d = (state_d == RUN);
  end

  // Status outputs follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_no <= 1'b0;
      led_r_no    <= 1'b0;
    end else begin
      core_rst_no <= run_d;
      led_r_no    <= run_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q == HOLD) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end

  logic             cs_ram_q;
  logic             cs_rom_q;
  logic             cs_fall;
  logic [STR_W-1:0] stretch_q;

  // Previous chip selects idle high outside RUN, so RUN entry never sees a fake edge.
  assign cs_fall = run && ((cs_ram_q && !mem_cs_ram_ni) || (cs_rom_q && !mem_cs_rom_ni));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cs_ram_q  <= 1'b1;
      cs_rom_q  <= 1'b1;
      stretch_q <= '0;
      led_g_no  <= 1'b1;
    end else begin
      if (run) begin
        cs_ram_q <= mem_cs_ram_ni;
        cs_rom_q <= mem_cs_rom_ni;
      end
      if (cs_fall) begin
        stretch_q <= STRETCH_LOAD;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - STR_W'(1);
      end
      led_g_no <= (stretch_q == '0);
    end
  end

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_ph_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (run) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else if (run) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  assign pwm_q = (pwm_cnt_q < duty_i);

  logic [GPOCNT-1:0] gpo_d;

  // Pins are held low outside RUN even for inverted channels.
  always_comb begin
    gpo_d = '0;
    for (int k = 0; k < GPOCNT; k++) begin
      unique case (gpo_mode_e'(mode_i[2*k +: 2]))
        GPO_DIRECT: gpo_d[k] = gpo_i[k];
        GPO_INV:    gpo_d[k] = ~gpo_i[k];
        GPO_BLINK:  gpo_d[k] = gpo_i[k] & blink_ph_q;
        GPO_PWM:    gpo_d[k] = gpo_i[k] & pwm_q;
      endcase
    end
    if (!run) begin
      gpo_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      gpo_o <= '0;
    end else begin
      gpo_o <= gpo_d;
    end
  end

endmodule
